// File: rtl/aes_pkg.sv
// Shared AES types and constants for the round sequencer and its datapath companion.
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_seq_state_e;

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: owns the state register and round counter.
// Optional block counter output is enabled by defining AES_ROUND_SEQ_BLKCNT_EN.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic [127:0] dp_state,
  output logic         dp_shift_en,
  output logic         dp_mix_en,
  input  logic [127:0] dp_result,
`ifdef AES_ROUND_SEQ_BLKCNT_EN
  output logic [31:0]  blk_count,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [3:0] LastRnd = 4'(NR);

  aes_seq_state_e fsm_q, fsm_d;
  logic [3:0]     rnd_q, rnd_d;
  aes_state_t     state_q, state_d;
  logic           accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      rnd_q   <= 4'd0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    state_d     = state_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    key_idx     = 4'd0;
    dp_shift_en = 1'b0;
    dp_mix_en   = 1'b0;
    accept      = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      ROUND: begin
        if (rnd_q == 4'd0 || rnd_q > LastRnd) begin
          // Corrupted round counter: abandon the block rather than run off the key table.
          fsm_d = IDLE;
          rnd_d = 4'd0;
        end else begin
          key_idx     = rnd_q;
          dp_shift_en = 1'b1;
          dp_mix_en   = (rnd_q != LastRnd);
          state_d     = dp_result;
          if (rnd_q == LastRnd) begin
            fsm_d = DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          fsm_d  = IDLE;
          rnd_d  = 4'd0;
          accept = in_valid;
        end
      end
      default: begin
        fsm_d = IDLE;
        rnd_d = 4'd0;
      end
    endcase

    // Accept shares the IDLE and DONE paths so back-to-back blocks lose no cycle.
    if (accept) begin
      state_d = in_data ^ round_key;
      rnd_d   = 4'd1;
      fsm_d   = ROUND;
    end
  end

  assign dp_state = state_q;
  assign out_data = state_q;

`ifdef AES_ROUND_SEQ_BLKCNT_EN
  logic [31:0] blk_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count_q <= 32'd0;
    end else if (out_valid && out_ready) begin
      blk_count_q <= blk_count_q + 32'd1;
    end
  end

  assign blk_count = blk_count_q;
`endif

endmodule
